// File: rtl/adder_fnd.sv
// 8-bit unsigned adder shown in decimal on a 4-digit
// multiplexed 7-segment display, with carry on an LED.
module adder_fnd #(
  parameter int CLK_DIV = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_data,
  output logic       led
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  localparam logic [1:0] DIG_ONES  = 2'd0;
  localparam logic [1:0] DIG_TENS  = 2'd1;
  localparam logic [1:0] DIG_HUND  = 2'd2;
  localparam logic [1:0] DIG_THOU  = 2'd3;

  logic [CW-1:0] cnt;
  logic [1:0]    sel;
  logic          wrap;
  logic [8:0]    sum;
  logic [11:0]   bcd;
  logic [3:0]    digit;
  logic [3:0]    com_nxt;
  logic [7:0]    seg_nxt;

  // Shift-add-3 conversion; 9 input bits fit in 3 BCD digits.
  function automatic logic [11:0] bin2bcd(
    input logic [8:0] bin
  );
    logic [20:0] s;
    s = {12'd0, bin};
    for (int i = 0; i < 9; i++) begin
      for (int d = 0; d < 3; d++) begin
        if (s[9+4*d +: 4] >= 4'd5)
          s[9+4*d +: 4] = s[9+4*d +: 4] + 4'd3;
      end
      s = s << 1;
    end
    return s[20:9];
  endfunction

  function automatic logic [7:0] seg7(
    input logic [3:0] v
  );
    logic [7:0] c;
    case (v)
      4'd0:    c = 8'hC0;
      4'd1:    c = 8'hF9;
      4'd2:    c = 8'hA4;
      4'd3:    c = 8'hB0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hF8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

  assign sum  = {1'b0, a} + {1'b0, b};
  assign bcd  = bin2bcd(sum);
  assign wrap = (cnt == CNT_MAX);

  always_comb begin
    digit   = 4'd0;
    com_nxt = 4'b1111;
    case (sel)
      DIG_ONES: begin
        digit   = bcd[3:0];
        com_nxt = 4'b1110;
      end
      DIG_TENS: begin
        digit   = bcd[7:4];
        com_nxt = 4'b1101;
      end
      DIG_HUND: begin
        digit   = bcd[11:8];
        com_nxt = 4'b1011;
      end
      DIG_THOU: begin
        digit   = 4'd0;
        com_nxt = 4'b0111;
      end
      default: begin
        digit   = 4'd0;
        com_nxt = 4'b1111;
      end
    endcase
  end

  assign seg_nxt = seg7(digit);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      sel <= DIG_ONES;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap)
        sel <= sel + 2'd1;
    end
  end

  // Outputs follow the select value held before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      fnd_com  <= 4'b1111;
      fnd_data <= 8'hFF;
      led      <= 1'b0;
    end else begin
      fnd_com  <= com_nxt;
      fnd_data <= seg_nxt;
      led      <= sum[8];
    end
  end

endmodule

// File: tb/tb_adder_fnd.sv
// Directed bench for adder_fnd with an expected-value
// queue filled at drive time and drained after each edge.
module tb_adder_fnd;

  localparam int DIV = 4;

  typedef struct {
    logic [3:0] com;
    logic [7:0] data;
    logic       led;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;
  logic       led;

  exp_t q[$];
  int   n_cmp;
  int   n_bad;
  int   k;

  logic [7:0] segtab [0:9];

  adder_fnd #(.CLK_DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .fnd_com  (fnd_com),
    .fnd_data (fnd_data),
    .led      (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic r);
    exp_t e;
    int   s;
    int   d;
    s = int'(a) + int'(b);
    if (r) begin
      e.com  = 4'b1111;
      e.data = 8'hFF;
      e.led  = 1'b0;
    end else begin
      d = (k / DIV) % 4;
      e.led = (s > 255);
      case (d)
        0: begin
          e.com  = 4'b1110;
          e.data = segtab[s % 10];
        end
        1: begin
          e.com  = 4'b1101;
          e.data = segtab[(s / 10) % 10];
        end
        2: begin
          e.com  = 4'b1011;
          e.data = segtab[(s / 100) % 10];
        end
        default: begin
          e.com  = 4'b0111;
          e.data = segtab[0];
        end
      endcase
    end
    return e;
  endfunction

  task automatic step(input logic r);
    exp_t e;
    exp_t g;
    reset = r;
    e = model(r);
    q.push_back(e);
    if (r) k = 0;
    else   k++;
    @(posedge clk);
    #1;
    n_cmp++;
    assert (q.size() != 0) else begin
      n_bad++;
      $error("FAIL queue obs=empty exp=entry");
    end
    if (q.size() != 0) begin
      g = q.pop_front();
      n_cmp++;
      assert (fnd_com === g.com) else begin
        n_bad++;
        $error("FAIL fnd_com obs=%b exp=%b t=%0t",
               fnd_com, g.com, $time);
      end
      n_cmp++;
      assert (fnd_data === g.data) else begin
        n_bad++;
        $error("FAIL fnd_data obs=%h exp=%h t=%0t",
               fnd_data, g.data, $time);
      end
      n_cmp++;
      assert (led === g.led) else begin
        n_bad++;
        $error("FAIL led obs=%b exp=%b t=%0t",
               led, g.led, $time);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin
    segtab[0] = 8'hC0; segtab[1] = 8'hF9;
    segtab[2] = 8'hA4; segtab[3] = 8'hB0;
    segtab[4] = 8'h99; segtab[5] = 8'h92;
    segtab[6] = 8'h82; segtab[7] = 8'hF8;
    segtab[8] = 8'h80; segtab[9] = 8'h90;
    n_cmp = 0;
    n_bad = 0;
    k     = 0;
    reset = 1'b1;
    a     = 8'h1F;
    b     = 8'h30;
    @(negedge clk);

    step(1'b1);
    run(32);

    a = 8'hFF; b = 8'hFF;
    step(1'b1);
    run(16);

    a = 8'h80; b = 8'h80;
    step(1'b1);
    run(16);

    a = 8'h00; b = 8'h00;
    step(1'b1);
    run(16);

    a = 8'h1F; b = 8'h30;
    step(1'b1);
    for (int i = 0; i < 64; i++)
      if ((k / DIV) % 4 != 2) step(1'b0);
    step(1'b0);
    step(1'b1);
    step(1'b1);
    run(8);

    step(1'b1);
    run(2);
    a = 8'h01;
    run(14);
    a = 8'hC8; b = 8'h64;
    run(3);
    b = 8'h37;
    run(9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
